// File: rtl/control_fsm.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives the datapath
// control inputs, traps on illegal opcodes or data-memory timeout, counts retirements.
module control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_BITS    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [3:0]          alu_flags,
  input  logic                d_mem_ready,
  output logic                d_mem_we,
  output logic                rf_we,
  output logic [3:0]          alu_cmd,
  output logic                alu_src,
  output logic                pc_src,
  output logic                rf_src,
  output logic                ir_we,
  output logic                pc_we,
  output logic                instr_done,
  output logic                trap,
  output logic [CNT_BITS-1:0] instr_count,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [6:0]          op_q, op_d;
  logic [7:0]          wait_q, wait_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                unused_flags;

  assign unused_flags = ^alu_flags[2:0];

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL: is_legal = 1'b1;
      default:                                                 is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] cmd_of(input logic [6:0] op);
    case (op)
      OP_I, OP_LOAD: cmd_of = 4'b0001;
      OP_STORE:      cmd_of = 4'b0010;
      OP_BRANCH:     cmd_of = 4'b0011;
      OP_LUI:        cmd_of = 4'b0100;
      OP_JAL:        cmd_of = 4'b0101;
      default:       cmd_of = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // op_q is pure data: it is always rewritten in DECODE before it is used
  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wait_d   = wait_q;
    d_mem_we = 1'b0;
    rf_we    = 1'b0;
    alu_cmd  = 4'b0000;
    alu_src  = 1'b1;
    pc_src   = 1'b1;
    rf_src   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    trap     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = opcode;
        state_d = is_legal(opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_cmd = cmd_of(op_q);
        alu_src = (op_q == OP_R) || (op_q == OP_BRANCH);
        case (op_q)
          OP_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = ~alu_flags[3];
            state_d = S_FETCH;
          end
          OP_JAL: begin
            pc_we   = 1'b1;
            pc_src  = 1'b0;
            state_d = S_FETCH;
          end
          OP_LOAD, OP_STORE: begin
            wait_d  = '0;
            state_d = S_MEM;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        alu_cmd  = cmd_of(op_q);
        alu_src  = 1'b0;
        d_mem_we = (op_q == OP_STORE);
        rf_src   = (op_q == OP_LOAD);
        if (d_mem_ready) begin
          if (op_q == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          // timeout abandons the access: the TRAP state itself suppresses all strobes
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        alu_cmd = cmd_of(op_q);
        alu_src = (op_q == OP_R);
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        rf_src  = (op_q == OP_LOAD);
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // while reset is held every control output shows its idle value
    if (rst) begin
      d_mem_we = 1'b0;
      rf_we    = 1'b0;
      alu_cmd  = 4'b0000;
      alu_src  = 1'b1;
      pc_src   = 1'b1;
      rf_src   = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      trap     = 1'b0;
    end
  end

  assign cnt_d       = pc_we ? cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1} : cnt_q;
  assign instr_done  = pc_we;
  assign instr_count = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: an instruction-level timeline model queues the expected
// outputs of every cycle, and a negedge process compares them against the DUT.
module tb_control_fsm;

  localparam int TO = 15;

  logic       clk, rst;
  logic [6:0] opcode;
  logic [3:0] alu_flags;
  logic       d_mem_ready;
  logic       d_mem_we, rf_we, alu_src, pc_src, rf_src, ir_we, pc_we, instr_done, trap;
  logic [3:0] alu_cmd;
  logic [3:0] instr_count;
  logic [2:0] state_dbg;

  control_fsm #(.MEM_TIMEOUT(TO), .CNT_BITS(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_flags(alu_flags), .d_mem_ready(d_mem_ready),
    .d_mem_we(d_mem_we), .rf_we(rf_we), .alu_cmd(alu_cmd), .alu_src(alu_src), .pc_src(pc_src),
    .rf_src(rf_src), .ir_we(ir_we), .pc_we(pc_we), .instr_done(instr_done), .trap(trap),
    .instr_count(instr_count), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we, pc_we, rf_we, dwe;
    logic [3:0] cmd;
    logic       asrc, psrc, rsrc, trap;
    logic [3:0] cnt;
  } exp_t;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, LUI = 7'b0110111, JAL = 7'b1101111, BAD = 7'b1111111;

  exp_t exq[$];
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;
  int   cyc_no = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    exp_t ce, act;
    if (exq.size() > 0) begin
      ce  = exq.pop_front();
      act = {state_dbg, ir_we, pc_we, rf_we, d_mem_we, alu_cmd, alu_src, pc_src, rf_src,
             trap, instr_count};
      total++;
      if (act !== ce || instr_done !== ce.pc_we) begin
        bad++;
        $display("FAIL cycle%0d outputs: got st=%0d ir=%b pc=%b rf=%b dwe=%b cmd=%b as=%b ps=%b rs=%b tr=%b cnt=%0d done=%b, want st=%0d ir=%b pc=%b rf=%b dwe=%b cmd=%b as=%b ps=%b rs=%b tr=%b cnt=%0d",
                 cyc_no, act.st, act.ir_we, act.pc_we, act.rf_we, act.dwe, act.cmd, act.asrc,
                 act.psrc, act.rsrc, act.trap, act.cnt, instr_done, ce.st, ce.ir_we, ce.pc_we,
                 ce.rf_we, ce.dwe, ce.cmd, ce.asrc, ce.psrc, ce.rsrc, ce.trap, ce.cnt);
      end
    end
  end

  task automatic check(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  function automatic exp_t base(input logic [2:0] st);
    exp_t e;
    e      = '0;
    e.st   = st;
    e.asrc = 1'b1;
    e.psrc = 1'b1;
    e.cnt  = 4'(model_cnt);
    return e;
  endfunction

  function automatic logic [3:0] cls_cmd(input logic [6:0] op);
    case (op)
      I, LD:   return 4'b0001;
      ST:      return 4'b0010;
      BR:      return 4'b0011;
      LUI:     return 4'b0100;
      JAL:     return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic next_cycle(input logic [6:0] op, input logic [3:0] fl, input logic rdy,
                            input exp_t e);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    opcode      = op;
    alu_flags   = fl;
    d_mem_ready = rdy;
    cyc_no++;
    exq.push_back(e);
    if (e.pc_we) model_cnt = (model_cnt + 1) % 16;
  endtask

  task automatic reset_cycle();
    exp_t e;
    @(posedge clk);
    #1;
    rst         = 1'b1;
    d_mem_ready = 1'b0;
    cyc_no++;
    model_cnt = 0;
    e = base(3'd0);
    exq.push_back(e);
  endtask

  task automatic trap_cycles(input logic [6:0] op);
    exp_t e;
    for (int t = 0; t < 3; t++) begin
      e      = base(3'd7);
      e.trap = 1'b1;
      next_cycle(op, 4'h0, 1'b0, e);
    end
  endtask

  // One instruction as a list of cycles. nwait = MEM cycles with ready low before ready rises;
  // abort_k >= 0 asserts reset in place of that MEM cycle.
  task automatic run_instr(input logic [6:0] op, input logic [3:0] fl, input int nwait,
                           input int abort_k, output int ncyc, output int nmem);
    exp_t e;
    logic legal, rdy, mem_op;
    legal  = (op == R) || (op == I) || (op == LD) || (op == ST) || (op == BR) ||
             (op == LUI) || (op == JAL);
    mem_op = (op == LD) || (op == ST);
    ncyc = 0;
    nmem = 0;
    e = base(3'd0); e.ir_we = 1'b1;
    next_cycle(op, fl, 1'b0, e); ncyc++;
    e = base(3'd1);
    next_cycle(op, fl, 1'b0, e); ncyc++;
    if (!legal) begin
      trap_cycles(op);
      return;
    end
    e = base(3'd2); e.cmd = cls_cmd(op); e.asrc = (op == R) || (op == BR);
    if (op == BR) begin e.pc_we = 1'b1; e.psrc = ~fl[3]; end
    if (op == JAL) begin e.pc_we = 1'b1; e.psrc = 1'b0; end
    next_cycle(op, fl, 1'b0, e); ncyc++;
    if (op == BR || op == JAL) return;
    if (mem_op) begin
      for (int k = 0; ; k++) begin
        if (k == abort_k) begin
          reset_cycle();
          return;
        end
        rdy = (k == nwait);
        e = base(3'd3); e.cmd = cls_cmd(op); e.asrc = 1'b0;
        e.dwe  = (op == ST);
        e.rsrc = (op == LD);
        if (rdy && op == ST) e.pc_we = 1'b1;
        next_cycle(op, fl, rdy, e); ncyc++; nmem++;
        if (rdy) break;
        if (k + 1 == TO) begin
          trap_cycles(op);
          return;
        end
      end
      if (op == ST) return;
    end
    e = base(3'd4); e.cmd = cls_cmd(op); e.asrc = (op == R);
    e.rf_we = 1'b1; e.pc_we = 1'b1; e.rsrc = (op == LD);
    next_cycle(op, fl, 1'b0, e); ncyc++;
  endtask

  initial begin
    int nc, nm;
    rst         = 1'b1;
    opcode      = 7'h0;
    alu_flags   = 4'h0;
    d_mem_ready = 1'b0;
    begin
      exp_t e;
      @(posedge clk); #1;
      e = base(3'd0);
      exq.push_back(e);
    end

    run_instr(R, 4'h0, 0, -1, nc, nm);
    check("R_latency", nc, 4);
    check("R_count", model_cnt, 1);
    run_instr(BR, 4'b1000, 0, -1, nc, nm);
    check("BR_latency", nc, 3);
    run_instr(BR, 4'b0111, 0, -1, nc, nm);
    run_instr(I, 4'h0, 0, -1, nc, nm);
    run_instr(LUI, 4'h0, 0, -1, nc, nm);
    run_instr(JAL, 4'b1000, 0, -1, nc, nm);
    run_instr(LD, 4'h0, 3, -1, nc, nm);
    check("LOAD_wait3_cycles", nc, 8);
    check("LOAD_mem_cycles", nm, 4);
    run_instr(ST, 4'h0, 0, -1, nc, nm);
    check("STORE_fast_cycles", nc, 4);
    check("count_after_8", model_cnt, 8);
    run_instr(ST, 4'h0, 1000, -1, nc, nm);
    check("STORE_timeout_mem_cycles", nm, 15);
    reset_cycle();
    run_instr(BAD, 4'h0, 0, -1, nc, nm);
    reset_cycle();
    run_instr(R, 4'h0, 0, -1, nc, nm);
    run_instr(LD, 4'h0, 5, 2, nc, nm);
    check("count_after_abort", model_cnt, 0);
    run_instr(LD, 4'h0, 0, -1, nc, nm);
    check("LOAD_fast_cycles", nc, 5);
    for (int n = 0; n < 15; n++) run_instr(R, 4'h0, 0, -1, nc, nm);
    check("count_wrap", model_cnt, 0);
    run_instr(ST, 4'h0, 2, -1, nc, nm);

    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
